// File: rtl/tdc_uart_rx.sv
// tdc_uart_rx: UART receiver that assembles SYNC/HI/LO byte frames into
// 16-bit TDC measurements with a valid/ready handshake, a sticky overrun flag
// and a one-cycle stop-bit error pulse.
module tdc_uart_rx #(
   parameter int          CLKS_PER_BIT = 104,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int          GAP_BITS     = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   output logic [15:0] meas,
   output logic        meas_valid,
   input  logic        meas_ready,
   output logic        frame_err,
   output logic        overrun
);

   // Bit engine states
   localparam logic [1:0] ENG_IDLE  = 2'd0;
   localparam logic [1:0] ENG_START = 2'd1;
   localparam logic [1:0] ENG_DATA  = 2'd2;
   localparam logic [1:0] ENG_STOP  = 2'd3;

   // Frame assembler states
   localparam logic [1:0] ASM_HUNT = 2'd0;
   localparam logic [1:0] ASM_HI   = 2'd1;
   localparam logic [1:0] ASM_LO   = 2'd2;

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TIMER_MAX = '1;

   // Gap counter must be able to represent one count beyond the limit
   localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
   localparam int GW = $clog2(GAP_LIMIT + 2);
   localparam logic [GW-1:0] GAP_SAT = GW'(GAP_LIMIT + 1);

   logic          rx_s1_q, rx_s2_q;
   logic          rx_sync;
   logic [1:0]    eng_q, eng_d;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          byte_stb_q, byte_stb_d;
   logic          frame_err_q, frame_err_d;
   logic [1:0]    asm_q, asm_d;
   logic [7:0]    hi_q, hi_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [15:0]   meas_q, meas_d;
   logic          valid_q, valid_d;
   logic          overrun_q, overrun_d;
   logic          start_det, gap_expired, frame_done, xfer;

   assign rx_sync = rx_s2_q;

   // Two-flop synchronizer for the asynchronous line, idling high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
      end else begin
         rx_s1_q <= rx;
         rx_s2_q <= rx_s1_q;
      end
   end

   assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
   assign start_det = (eng_q == ENG_IDLE) && !rx_sync;

   // Bit engine: start validation at mid-bit, then sample once per bit period
   always_comb begin
      eng_d       = eng_q;
      timer_d     = timer_inc;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      byte_stb_d  = 1'b0;
      frame_err_d = 1'b0;
      case (eng_q)
         ENG_IDLE: begin
            timer_d = '0;
            if (!rx_sync) eng_d = ENG_START;
         end
         ENG_START: begin
            if (timer_q == HALF_LAST) begin
               timer_d   = '0;
               bit_cnt_d = 3'd0;
               eng_d     = rx_sync ? ENG_IDLE : ENG_DATA;
            end
         end
         ENG_DATA: begin
            if (timer_q == BIT_LAST) begin
               timer_d   = '0;
               shift_d   = {rx_sync, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) eng_d = ENG_STOP;
            end
         end
         default: begin
            if (timer_q == BIT_LAST) begin
               timer_d     = '0;
               eng_d       = ENG_IDLE;
               byte_stb_d  = rx_sync;
               frame_err_d = !rx_sync;
            end
         end
      endcase
   end

   // Bit engine registers; the received byte stays in shift_q while the strobe is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_q       <= ENG_IDLE;
         timer_q     <= '0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         byte_stb_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         eng_q       <= eng_d;
         timer_q     <= timer_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         byte_stb_q  <= byte_stb_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign gap_expired = (gap_q == GAP_SAT);
   assign xfer        = valid_q && meas_ready;

   // Frame assembler, inter-byte gap timeout and measurement handshake
   always_comb begin
      asm_d      = asm_q;
      hi_d       = hi_q;
      gap_d      = gap_q;
      meas_d     = meas_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q;
      frame_done = 1'b0;

      if (asm_q == ASM_HUNT || byte_stb_q)
         gap_d = '0;
      else if (eng_q == ENG_IDLE && !gap_expired)
         gap_d = gap_q + GW'(1);

      if (frame_err_q && asm_q != ASM_HUNT) begin
         asm_d = ASM_HUNT;
      end else if (start_det && gap_expired && asm_q != ASM_HUNT) begin
         asm_d = ASM_HUNT;
      end else if (byte_stb_q) begin
         case (asm_q)
            ASM_HUNT: if (shift_q == SYNC_BYTE) asm_d = ASM_HI;
            ASM_HI: begin
               hi_d  = shift_q;
               asm_d = ASM_LO;
            end
            default: begin
               frame_done = 1'b1;
               asm_d      = ASM_HUNT;
            end
         endcase
      end

      if (frame_done) begin
         if (!valid_q || meas_ready) begin
            meas_d  = {hi_q, shift_q};
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   // Assembler and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q     <= ASM_HUNT;
         hi_q      <= 8'h00;
         gap_q     <= '0;
         meas_q    <= 16'h0000;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         asm_q     <= asm_d;
         hi_q      <= hi_d;
         gap_q     <= gap_d;
         meas_q    <= meas_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign meas       = meas_q;
   assign meas_valid = valid_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule
